// File: rtl/i2s_sample_framer.sv
// i2s_sample_framer: converts I2S samples to OUT_RES bits (round half up,
// positive saturation) and packs them into ping-pong frames of FRAME_LEN
// samples for an FFT. Frames leave in write order. While both banks are
// occupied, incoming samples are dropped and counted.
//
// Output handshake: a sample transfers on every clk_i edge where
// out_valid_o && out_ready_i. Once out_valid_o is high, it stays high and
// out_data_o/out_last_o stay unchanged until that transfer happens.
// out_ready_i may change freely and does not combinationally affect any output.
module i2s_sample_framer #(
  parameter int DATA_RES  = 24,
  parameter int OUT_RES   = 16,
  parameter int FRAME_LEN = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DATA_RES-1:0] sample_i,
  input  logic                sample_valid_i,
  output logic [OUT_RES-1:0]  out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                out_last_o,
  output logic                overflow_o,
  output logic [15:0]         drop_cnt_o,
  output logic [1:0]          dbg_state_o   // {write FSM in STALL, read FSM in STREAM}
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [OUT_RES-1:0] MAX_POS = {1'b0, {(OUT_RES-1){1'b1}}};

  typedef enum logic [1:0] { B_EMPTY, B_FILLING, B_FULL } bank_e;
  typedef enum logic { W_FILL, W_STALL } wr_state_e;
  typedef enum logic { R_IDLE, R_STREAM } rd_state_e;

  // Frame storage; contents only become visible once a bank is FULL, so no reset.
  logic [OUT_RES-1:0] mem_q [2][FRAME_LEN];

  bank_e            bank_q [2];
  bank_e            bank_d [2];
  wr_state_e        wr_state_q, wr_state_d;
  logic             wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  rd_state_e        rd_state_q, rd_state_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [OUT_RES-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic             we;
  logic             we_bank;
  logic [IDX_W-1:0] we_idx;
  logic             drop;
  logic             other_bank;
  logic             load;

  logic [OUT_RES-1:0] conv_top;
  logic               conv_rnd;
  logic [OUT_RES-1:0] conv;
  logic [DATA_RES-OUT_RES-2:0] unused_low_bits;

  assign unused_low_bits = sample_i[DATA_RES-OUT_RES-2:0];

  // Truncate to OUT_RES bits and add the round bit; only the largest
  // positive value can overflow, so that single case is clamped.
  always_comb begin
    conv_top = sample_i[DATA_RES-1 -: OUT_RES];
    conv_rnd = sample_i[DATA_RES-OUT_RES-1];
    if (conv_rnd && (conv_top == MAX_POS)) begin
      conv = MAX_POS;
    end else begin
      conv = conv_top + {{(OUT_RES-1){1'b0}}, conv_rnd};
    end
  end

  assign other_bank = ~wr_bank_q;

  // Next-state logic for the write FSM, bank states and the read FSM.
  always_comb begin
    bank_d      = bank_q;
    wr_state_d  = wr_state_q;
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    rd_state_d  = rd_state_q;
    rd_bank_d   = rd_bank_q;
    rd_idx_d    = rd_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    we          = 1'b0;
    we_bank     = wr_bank_q;
    we_idx      = wr_idx_q;
    drop        = 1'b0;
    load        = 1'b0;

    // Write side: the write bank is never FULL while in W_FILL.
    case (wr_state_q)
      W_FILL: begin
        if (sample_valid_i) begin
          we = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            bank_d[wr_bank_q] = B_FULL;
            wr_idx_d          = '0;
            if (bank_q[other_bank] == B_EMPTY) begin
              wr_bank_d = other_bank;
            end else begin
              wr_state_d = W_STALL;
            end
          end else begin
            bank_d[wr_bank_q] = B_FILLING;
            wr_idx_d          = wr_idx_q + IDX_W'(1);
          end
        end
      end
      W_STALL: begin
        // The freed bank is only seen one edge after the read side empties
        // it, so a strobe on the freeing edge itself falls into the drop path.
        if (bank_q[other_bank] == B_EMPTY) begin
          wr_state_d = W_FILL;
          wr_bank_d  = other_bank;
          if (sample_valid_i) begin
            we                 = 1'b1;
            we_bank            = other_bank;
            we_idx             = '0;
            bank_d[other_bank] = B_FILLING;
            wr_idx_d           = IDX_W'(1);
          end
        end else if (sample_valid_i) begin
          drop = 1'b1;
        end
      end
      default: wr_state_d = W_FILL;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end

    // Read side: the bank that is not the current write bank is the older
    // one whenever both are FULL (the write side stalls on the newer one).
    case (rd_state_q)
      R_IDLE: begin
        if (bank_q[other_bank] == B_FULL) begin
          rd_state_d = R_STREAM;
          rd_bank_d  = other_bank;
          rd_idx_d   = '0;
        end else if (bank_q[wr_bank_q] == B_FULL) begin
          rd_state_d = R_STREAM;
          rd_bank_d  = wr_bank_q;
          rd_idx_d   = '0;
        end
      end
      R_STREAM: begin
        load = !out_valid_q || (out_ready_i && !out_last_q);
        if (load) begin
          out_valid_d = 1'b1;
          out_data_d  = mem_q[rd_bank_q][rd_idx_q];
          out_last_d  = (rd_idx_q == LAST_IDX);
          rd_idx_d    = rd_idx_q + IDX_W'(1);
        end else if (out_valid_q && out_ready_i && out_last_q) begin
          out_valid_d       = 1'b0;
          out_last_d        = 1'b0;
          bank_d[rd_bank_q] = B_EMPTY;
          rd_state_d        = R_IDLE;
          rd_idx_d          = '0;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // State registers; reset discards every frame and returns to bank A.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_q[0]   <= B_EMPTY;
      bank_q[1]   <= B_EMPTY;
      wr_state_q  <= W_FILL;
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_state_q  <= R_IDLE;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      bank_q      <= bank_d;
      wr_state_q  <= wr_state_d;
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_state_q  <= rd_state_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Sample memory write port; strobes during reset are ignored.
  always_ff @(posedge clk_i) begin
    if (!rst_i && we) begin
      mem_q[we_bank][we_idx] <= conv;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;
  assign dbg_state_o = {wr_state_q == W_STALL, rd_state_q == R_STREAM};

endmodule

// File: tb/tb_i2s_sample_framer.sv
// Directed bench for i2s_sample_framer with FRAME_LEN=8.
module tb_i2s_sample_framer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [23:0] sample_i;
  logic        sample_valid_i;
  logic [15:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        out_last_o;
  logic        overflow_o;
  logic [15:0] drop_cnt_o;
  logic [1:0]  dbg_state_o;

  int errors = 0;
  int checks = 0;
  int last_cnt;
  logic [16:0] exp_q [$];   // {last, data}

  i2s_sample_framer #(.DATA_RES(24), .OUT_RES(16), .FRAME_LEN(8)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .out_data_o     (out_data_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_last_o     (out_last_o),
    .overflow_o     (overflow_o),
    .drop_cnt_o     (drop_cnt_o),
    .dbg_state_o    (dbg_state_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] mk(input int k);
    logic [15:0] v;
    v = 16'(k);
    return {v, 8'h00};
  endfunction

  // Driver: one strobe per cycle.
  task automatic strobe(input logic [23:0] v);
    sample_i       = v;
    sample_valid_i = 1'b1;
    tick();
    sample_valid_i = 1'b0;
  endtask

  // Strobe k0..k0+7 and queue the expected frame.
  task automatic write_frame(input int k0);
    for (int i = 0; i < 8; i++) begin
      strobe(mk(k0 + i));
      exp_q.push_back({(i == 7), 16'(k0 + i)});
    end
  endtask

  // Consume the expected queue, checking hold-during-stall and the inter-frame gap.
  task automatic drain(input bit rnd, input int budget);
    logic        prev_stall = 1'b0;
    logic        prev_xfer_last = 1'b0;
    logic [16:0] prev_out = '0;
    logic [16:0] e;
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid_o), 32'd1);
        chk("hold_data", 32'({out_last_o, out_data_o}), 32'(prev_out));
      end
      if (prev_xfer_last) chk("frame_gap", 32'(out_valid_o), 32'd0);
      out_ready_i    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall     = out_valid_o && !out_ready_i;
      prev_out       = {out_last_o, out_data_o};
      prev_xfer_last = 1'b0;
      if (out_valid_o && out_ready_i) begin
        e = exp_q.pop_front();
        chk("out_sample", 32'({out_last_o, out_data_o}), 32'(e));
        if (out_last_o) last_cnt++;
        prev_xfer_last = out_last_o;
      end
      tick();
      n++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    if (prev_xfer_last) chk("frame_gap", 32'(out_valid_o), 32'd0);
    out_ready_i = 1'b1;
  endtask

  logic [23:0] cv [8];
  logic [15:0] ce [8];
  logic        injected;
  int          n;
  logic [16:0] e;

  initial begin
    rst_i = 1'b1; sample_i = '0; sample_valid_i = 1'b0; out_ready_i = 1'b1;
    tick(); tick();
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_last", 32'(out_last_o), 32'd0);
    chk("rst_data", 32'(out_data_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_drop", 32'(drop_cnt_o), 32'd0);
    chk("rst_dbg", 32'(dbg_state_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // Conversion frame plus exact output latency, consecutive outputs.
    cv[0] = 24'hAABBCC; ce[0] = 16'hAABC;
    cv[1] = 24'h123400; ce[1] = 16'h1234;
    cv[2] = 24'h7FFFC0; ce[2] = 16'h7FFF;
    cv[3] = 24'h800000; ce[3] = 16'h8000;
    cv[4] = 24'hFFFF80; ce[4] = 16'h0000;
    cv[5] = 24'h00057F; ce[5] = 16'h0005;
    cv[6] = 24'h7FFF7F; ce[6] = 16'h7FFF;
    cv[7] = 24'h000880; ce[7] = 16'h0009;
    for (int i = 0; i < 8; i++) strobe(cv[i]);
    chk("lat_e0", 32'(out_valid_o), 32'd0);
    tick();
    chk("lat_e1", 32'(out_valid_o), 32'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("conv_valid", 32'(out_valid_o), 32'd1);
      chk("conv_data", 32'(out_data_o), 32'(ce[i]));
      chk("conv_last", 32'(out_last_o), 32'(i == 7));
      tick();
    end
    chk("conv_gap", 32'(out_valid_o), 32'd0);
    tick(); tick();

    // Values 1..8, ready held high: latency 2, consecutive outputs.
    for (int i = 1; i <= 8; i++) strobe(mk(i));
    tick(); tick();
    for (int i = 1; i <= 8; i++) begin
      chk("seq_valid", 32'(out_valid_o), 32'd1);
      chk("seq_data", 32'(out_data_o), 32'(i));
      chk("seq_last", 32'(out_last_o), 32'(i == 8));
      tick();
    end
    chk("seq_gap", 32'(out_valid_o), 32'd0);

    // Random ready during a frame.
    last_cnt = 0;
    write_frame(1);
    drain(1'b1, 400);
    chk("rand_last_cnt", 32'(last_cnt), 32'd1);

    // Ready low while 24 samples arrive: two frames kept, 8 dropped.
    last_cnt = 0;
    out_ready_i = 1'b0;
    write_frame(1);
    write_frame(9);
    for (int i = 17; i <= 24; i++) strobe(mk(i));
    tick();
    chk("ovf_set", 32'(overflow_o), 32'd1);
    chk("drop_cnt8", 32'(drop_cnt_o), 32'd8);
    chk("stall_dbg", 32'(dbg_state_o), 32'd3);
    drain(1'b0, 200);
    chk("two_frames_last", 32'(last_cnt), 32'd2);
    tick();
    chk("after_drain_dbg", 32'(dbg_state_o), 32'd0);
    chk("ovf_sticky", 32'(overflow_o), 32'd1);

    // Reset with one FULL bank and a partial frame; strobes during reset ignored.
    out_ready_i = 1'b0;
    for (int i = 0; i < 13; i++) strobe(mk(16'h21 + i));
    rst_i = 1'b1; sample_i = mk(16'h77); sample_valid_i = 1'b1;
    tick(); tick();
    chk("mrst_valid", 32'(out_valid_o), 32'd0);
    chk("mrst_last", 32'(out_last_o), 32'd0);
    chk("mrst_data", 32'(out_data_o), 32'd0);
    chk("mrst_ovf", 32'(overflow_o), 32'd0);
    chk("mrst_drop", 32'(drop_cnt_o), 32'd0);
    chk("mrst_dbg", 32'(dbg_state_o), 32'd0);
    rst_i = 1'b0; sample_valid_i = 1'b0;
    tick();
    exp_q.delete();
    write_frame(16'h31);
    drain(1'b0, 100);

    // Strobe on the bank-freeing edge is dropped; next strobe lands at index 0.
    out_ready_i = 1'b0;
    write_frame(16'h41);
    write_frame(16'h51);
    tick();
    chk("free_stall_dbg", 32'(dbg_state_o), 32'd3);
    injected = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      out_ready_i = 1'b1;
      sample_valid_i = 1'b0;
      if (out_valid_o) begin
        e = exp_q.pop_front();
        chk("free_sample", 32'({out_last_o, out_data_o}), 32'(e));
        if (out_last_o && !injected) begin
          sample_i = mk(16'h99);
          sample_valid_i = 1'b1;
          injected = 1'b1;
        end
      end
      tick();
      n++;
    end
    sample_valid_i = 1'b0;
    chk("free_drain_done", 32'(exp_q.size()), 32'd0);
    chk("free_injected", 32'(injected), 32'd1);
    chk("free_drop_cnt", 32'(drop_cnt_o), 32'd1);
    chk("free_ovf", 32'(overflow_o), 32'd1);
    write_frame(16'h61);
    drain(1'b1, 400);
    chk("free_drop_final", 32'(drop_cnt_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
